uart_tx_arbiter: RTL and testbench

Shares one UART transmitter between `NumReq` byte sources, such as the CPU MMIO console and the debug monitor. Arbitration is round-robin with message locking: once a requester wins, it keeps the transmitter until it flags the last byte of its message, or until it goes idle too long. The block sits between the requesters and the transmitter's DataIn/DataInValid/DataInReady handshake. It holds one byte in an output register.

---
 rtl/uart_tx_arbiter.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between NumReq byte sources. Round-robin
//   arbitration with message locking: the winner keeps the transmitter until
//   it hands over a byte flagged Last. One byte is held in the output register.
//
//   Optional feature macro: UART_ARB_TIMEOUT_EN
//     When defined, a locked owner that stays idle for LockTimeout LOCK cycles
//     loses the grant. When undefined, LOCK waits indefinitely.
//
// Parameters
//   NumReq      number of requesters (>= 2)
//   LockTimeout idle LOCK cycles tolerated before revoking the grant (>= 1)
//
// Ports
//   Clock     in   rising-edge clock
//   Reset     in   asynchronous active-high reset
//   ReqData   in   [8*NumReq] byte i in bits [8i+7:8i]
//   ReqValid  in   [NumReq]   requester i offers a byte
//   ReqLast   in   [NumReq]   offered byte ends requester i's message
//   ReqReady  out  [NumReq]   byte accepted when ReqValid[i] && ReqReady[i]
//   Grant     out  [NumReq]   one-hot current owner, zero when idle
//   TxData    out  [8]        transmitter DataIn
//   TxValid   out             transmitter DataInValid
//   TxReady   in              transmitter DataInReady
//   Busy      out             arbiter not idle
module uart_tx_arbiter #(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned LockTimeout = 1024
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [8*NumReq-1:0]   ReqData,
  input  logic [NumReq-1:0]     ReqValid,
  input  logic [NumReq-1:0]     ReqLast,
  output logic [NumReq-1:0]     ReqReady,
  output logic [NumReq-1:0]     Grant,
  output logic [7:0]            TxData,
  output logic                  TxValid,
  input  logic                  TxReady,
  output logic                  Busy
);

  localparam int unsigned PtrW = $clog2(NumReq);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLock = 2'd1,
    StSend = 2'd2
  } state_e;

  state_e              state_q;
  logic [PtrW-1:0]     ptr_q;
  logic [PtrW-1:0]     gidx_q;
  logic [NumReq-1:0]   grant_q;
  logic [7:0]          tx_data_q;
  logic                tx_valid_q;
  logic                last_q;

  logic [7:0]          req_byte [NumReq];
  logic                win_found_d;
  logic [PtrW-1:0]     win_idx_d;
  logic [PtrW-1:0]     cand_idx;
  int unsigned         cand_sum;
  logic [PtrW-1:0]     ptr_next;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(LockTimeout) + 1;
  logic [CntW-1:0]     idle_cnt_q;
`else
  // Parameter stays in the interface so overrides work in either build.
  logic                unused_lock_timeout;
  assign unused_lock_timeout = |LockTimeout;
`endif

  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      req_byte[i] = ReqData[8*i +: 8];
    end
  end

  // First valid requester at or after ptr_q, searching upward modulo NumReq.
  always_comb begin
    win_found_d = 1'b0;
    win_idx_d   = '0;
    cand_sum    = 0;
    cand_idx    = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand_sum = 32'(ptr_q) + i;
      if (cand_sum >= NumReq) begin
        cand_sum = cand_sum - NumReq;
      end
      cand_idx = PtrW'(cand_sum);
      if (!win_found_d && ReqValid[cand_idx]) begin
        win_found_d = 1'b1;
        win_idx_d   = cand_idx;
      end
    end
  end

  assign ptr_next = (gidx_q == PtrW'(NumReq - 1)) ? '0 : gidx_q + 1'b1;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      gidx_q     <= '0;
      grant_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      last_q     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      idle_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (win_found_d) begin
            grant_q <= NumReq'(1) << win_idx_d;
            gidx_q  <= win_idx_d;
            state_q <= StLock;
`ifdef UART_ARB_TIMEOUT_EN
            idle_cnt_q <= '0;
`endif
          end
        end
        StLock: begin
          if (ReqValid[gidx_q]) begin
            tx_data_q  <= req_byte[gidx_q];
            last_q     <= ReqLast[gidx_q];
            tx_valid_q <= 1'b1;
            state_q    <= StSend;
`ifdef UART_ARB_TIMEOUT_EN
            idle_cnt_q <= '0;
          end else if (idle_cnt_q == CntW'(LockTimeout - 1)) begin
            // This cycle is the LockTimeout-th idle one: revoke the grant.
            grant_q    <= '0;
            ptr_q      <= ptr_next;
            state_q    <= StIdle;
            idle_cnt_q <= '0;
          end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
`endif
          end
        end
        StSend: begin
          if (TxReady) begin
            tx_valid_q <= 1'b0;
            if (last_q) begin
              grant_q <= '0;
              ptr_q   <= ptr_next;
              state_q <= StIdle;
            end else begin
              state_q <= StLock;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Derived from registered state only, never from ReqValid.
  assign ReqReady = (state_q == StLock) ? grant_q : '0;
  assign Grant    = grant_q;
  assign TxData   = tx_data_q;
  assign TxValid  = tx_valid_q;
  assign Busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;

  logic            Clock = 1'b0;
  logic            Reset;
  logic [8*NR-1:0] ReqData;
  logic [NR-1:0]   ReqValid;
  logic [NR-1:0]   ReqLast;
  logic [NR-1:0]   ReqReady;
  logic [NR-1:0]   Grant;
  logic [7:0]      TxData;
  logic            TxValid;
  logic            TxReady;
  logic            Busy;

  always #5 Clock = ~Clock;

  uart_tx_arbiter #(
    .NumReq      (NR),
    .LockTimeout (8)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .ReqData  (ReqData),
    .ReqValid (ReqValid),
    .ReqLast  (ReqLast),
    .ReqReady (ReqReady),
    .Grant    (Grant),
    .TxData   (TxData),
    .TxValid  (TxValid),
    .TxReady  (TxReady),
    .Busy     (Busy)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Requester model: per-requester FIFO of {last, data}.
  logic [8:0]  mem [NR][16];
  int unsigned head [NR];
  int unsigned tail [NR];

  // Transfer log: {owner index, byte}.
  logic [10:0] txlog [64];
  int unsigned nlog;

  function automatic int unsigned oh2idx(input logic [NR-1:0] oh);
    for (int i = 0; i < NR; i++) if (oh[i]) return i;
    return 7;
  endfunction

  function automatic logic [31:0] ent(input int unsigned idx, input logic [7:0] d);
    logic [2:0] ix;
    ix = 3'(idx);
    return {21'b0, ix, d};
  endfunction

  task automatic push(input int unsigned r, input logic [7:0] d, input logic l);
    mem[r][tail[r]] = {l, d};
    tail[r]++;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  endtask

  task automatic clear_log();
    nlog = 0;
    for (int i = 0; i < 64; i++) txlog[i] = 'x;
  endtask

  task automatic drive();
    logic [8*NR-1:0] d;
    logic [NR-1:0]   v;
    logic [NR-1:0]   l;
    logic [8:0]      e;
    d = '0; v = '0; l = '0;
    for (int i = 0; i < NR; i++) begin
      if (head[i] != tail[i]) begin
        e = mem[i][head[i]];
        v[i] = 1'b1;
        l[i] = e[8];
        d[8*i +: 8] = e[7:0];
      end
    end
    ReqData  = d;
    ReqValid = v;
    ReqLast  = l;
  endtask

  // Record handshakes seen with the current (stable) values, advance one
  // clock, then pop accepted bytes and present the next ones at edge+1.
  task automatic step();
    logic [NR-1:0] hs;
    hs = ReqValid & ReqReady;
    if (TxValid && TxReady && nlog < 64) begin
      txlog[nlog] = {3'(oh2idx(Grant)), TxData};
      nlog++;
    end
    @(posedge Clock);
    #1;
    for (int i = 0; i < NR; i++) if (hs[i]) head[i]++;
    drive();
  endtask

  function automatic logic reqs_empty();
    for (int i = 0; i < NR; i++) if (head[i] != tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string tag, input int unsigned max);
    logic done;
    done = 1'b0;
    for (int unsigned k = 0; k < max; k++) begin
      if (reqs_empty() && !Busy && !TxValid) begin
        done = 1'b1;
        break;
      end
      step();
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  exp_byte [8];
    int unsigned hold;
    logic        ev;

    Reset   = 1'b1;
    TxReady = 1'b1;
    clear_reqs();
    clear_log();
    drive();
    #1;
    check("rst_ready", 32'(ReqReady), 32'd0);
    check("rst_grant", 32'(Grant), 32'd0);
    check("rst_txdata", 32'(TxData), 32'd0);
    check("rst_txvalid", 32'(TxValid), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    do_reset();

    // Single requester, 3 bytes, TxReady high.
    push(1, 8'h41, 1'b0);
    push(1, 8'h42, 1'b0);
    push(1, 8'h43, 1'b1);
    drive();
    exp_byte[2] = 8'h41;
    exp_byte[4] = 8'h42;
    exp_byte[6] = 8'h43;
    for (int c = 0; c < 8; c++) begin
      ev = (c == 2 || c == 4 || c == 6);
      check($sformatf("t1_valid_c%0d", c), 32'(TxValid), 32'(ev));
      check($sformatf("t1_grant_c%0d", c), 32'(Grant), (c >= 1 && c <= 6) ? 32'h2 : 32'h0);
      check($sformatf("t1_ready_c%0d", c), 32'(ReqReady), (c == 1 || c == 3 || c == 5) ? 32'h2 : 32'h0);
      check($sformatf("t1_busy_c%0d", c), 32'(Busy), (c >= 1 && c <= 6) ? 32'd1 : 32'd0);
      if (ev) check($sformatf("t1_data_c%0d", c), 32'(TxData), 32'(exp_byte[c]));
      step();
    end

    // Ptr is now 2: Req2 must beat Req1.
    clear_log();
    push(1, 8'h11, 1'b1);
    push(2, 8'h22, 1'b1);
    drive();
    wait_idle("t1_ptr_idle", 50);
    check("t1_ptr_first", 32'(txlog[0]), ent(2, 8'h22));
    check("t1_ptr_second", 32'(txlog[1]), ent(1, 8'h11));

    // Contention: Req0 and Req2 valid at reset release.
    Reset = 1'b1;
    clear_reqs();
    clear_log();
    TxReady = 1'b1;
    push(0, 8'hA0, 1'b0);
    push(0, 8'hA1, 1'b1);
    push(2, 8'hC0, 1'b0);
    push(2, 8'hC1, 1'b1);
    drive();
    do_reset();
    wait_idle("t2_idle", 50);
    check("t2_count", 32'(nlog), 32'd4);
    check("t2_b0", 32'(txlog[0]), ent(0, 8'hA0));
    check("t2_b1", 32'(txlog[1]), ent(0, 8'hA1));
    check("t2_b2", 32'(txlog[2]), ent(2, 8'hC0));
    check("t2_b3", 32'(txlog[3]), ent(2, 8'hC1));

    // Wrap: Ptr=3, Req3/Req0/Req1 all valid.
    clear_log();
    push(3, 8'hD3, 1'b1);
    push(0, 8'hD0, 1'b0);
    push(0, 8'hD1, 1'b1);
    push(1, 8'hE1, 1'b1);
    drive();
    wait_idle("t3_idle", 50);
    check("t3_count", 32'(nlog), 32'd4);
    check("t3_b0", 32'(txlog[0]), ent(3, 8'hD3));
    check("t3_b1", 32'(txlog[1]), ent(0, 8'hD0));
    check("t3_b2", 32'(txlog[2]), ent(0, 8'hD1));
    check("t3_b3", 32'(txlog[3]), ent(1, 8'hE1));

    // Backpressure: TxReady low for 100 cycles in SEND.
    clear_log();
    TxReady = 1'b0;
    push(0, 8'h5A, 1'b1);
    drive();
    for (int k = 0; k < 10 && !TxValid; k++) step();
    check("t4_txvalid_up", 32'(TxValid), 32'd1);
    hold = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (TxValid === 1'b1 && TxData === 8'h5A) hold++;
    end
    check("t4_hold", hold, 32'd100);
    check("t4_no_xfer", 32'(nlog), 32'd0);
    TxReady = 1'b1;
    step();
    check("t4_xfer", 32'(nlog), 32'd1);
    check("t4_byte", 32'(txlog[0]), ent(0, 8'h5A));
    check("t4_txvalid_down", 32'(TxValid), 32'd0);
    repeat (5) step();
    check("t4_no_dup", 32'(nlog), 32'd1);
    check("t4_idle", 32'(Busy), 32'd0);

    // Lock timeout behaviour.
    Reset = 1'b1;
    clear_reqs();
    clear_log();
    TxReady = 1'b1;
    push(1, 8'h31, 1'b0);
    push(2, 8'h32, 1'b1);
    drive();
    do_reset();
    step();
    check("t5_grant_c1", 32'(Grant), 32'h2);
`ifdef UART_ARB_TIMEOUT_EN
    repeat (9) step();
    check("t5_grant_c10", 32'(Grant), 32'h2);
    step();
    check("t5_grant_c11", 32'(Grant), 32'h0);
    step();
    check("t5_grant_c12", 32'(Grant), 32'h4);
    wait_idle("t5_idle", 50);
    check("t5_count", 32'(nlog), 32'd2);
    check("t5_b1", 32'(txlog[1]), ent(2, 8'h32));
`else
    repeat (1000) step();
    check("t5_grant_held", 32'(Grant), 32'h2);
    check("t5_count_held", 32'(nlog), 32'd1);
    push(1, 8'h33, 1'b1);
    drive();
    wait_idle("t5_idle", 50);
    check("t5_count", 32'(nlog), 32'd3);
    check("t5_b1", 32'(txlog[1]), ent(1, 8'h33));
    check("t5_b2", 32'(txlog[2]), ent(2, 8'h32));
`endif

    // Reset while TxValid is high.
    Reset = 1'b1;
    clear_reqs();
    clear_log();
    TxReady = 1'b0;
    push(0, 8'h77, 1'b1);
    drive();
    do_reset();
    step();
    step();
    check("t6_txvalid", 32'(TxValid), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    check("t6_ready", 32'(ReqReady), 32'd0);
    check("t6_grant", 32'(Grant), 32'd0);
    check("t6_txdata", 32'(TxData), 32'd0);
    check("t6_txvalid0", 32'(TxValid), 32'd0);
    check("t6_busy", 32'(Busy), 32'd0);
    clear_reqs();
    drive();
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    push(0, 8'h78, 1'b1);
    drive();
    check("t6_grant_c0", 32'(Grant), 32'h0);
    step();
    check("t6_grant_c1", 32'(Grant), 32'h1);
    check("t6_ready_c1", 32'(ReqReady), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
